// File: rtl/simd_regfile_pair.sv
// Scalar (NREGS x SW) and vector (NREGS x VW) architectural register files sharing
// one address set: three combinational read ports and one synchronous write port each.
module simd_regfile_pair #(
  parameter int NREGS    = 32,
  parameter int SW       = 16,
  parameter int VW       = 128,
  parameter int ZERO_REG = 0,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wre,
  input  logic [AW-1:0] a1,
  input  logic [AW-1:0] a2,
  input  logic [AW-1:0] a3,
  input  logic [SW-1:0] wd3_scalar,
  input  logic [VW-1:0] wd3_vector,
  output logic [SW-1:0] rd1_scalar,
  output logic [SW-1:0] rd2_scalar,
  output logic [SW-1:0] rd3_scalar,
  output logic [VW-1:0] rd1_vector,
  output logic [VW-1:0] rd2_vector,
  output logic [VW-1:0] rd3_vector
);

  logic [SW-1:0] scalar_r [NREGS];
  logic [VW-1:0] vector_r [NREGS];
  logic          wr_en_s;

  // Register 0 is hardwired to zero only when ZERO_REG is set.
  function automatic logic is_zero_reg(input logic [AW-1:0] addr);
    return (ZERO_REG != 0) && (addr == {AW{1'b0}});
  endfunction

  // Write qualification: only a clean 1 on wre writes, and never to a hardwired zero register.
  always_comb begin
    wr_en_s = 1'b0;
    if ((wre == 1'b1) && !is_zero_reg(a3)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Storage update: reset clears both files and wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        scalar_r[i] <= {SW{1'b0}};
        vector_r[i] <= {VW{1'b0}};
      end
    end else if (wr_en_s) begin
      scalar_r[a3] <= wd3_scalar;
      vector_r[a3] <= wd3_vector;
    end
  end

  // Combinational reads with no bypass; the written value shows up after the edge.
  always_comb begin
    rd1_scalar = {SW{1'b0}};
    rd2_scalar = {SW{1'b0}};
    rd3_scalar = {SW{1'b0}};
    rd1_vector = {VW{1'b0}};
    rd2_vector = {VW{1'b0}};
    rd3_vector = {VW{1'b0}};
    if (is_zero_reg(a1)) begin
      rd1_scalar = {SW{1'b0}};
      rd1_vector = {VW{1'b0}};
    end else begin
      rd1_scalar = scalar_r[a1];
      rd1_vector = vector_r[a1];
    end
    if (is_zero_reg(a2)) begin
      rd2_scalar = {SW{1'b0}};
      rd2_vector = {VW{1'b0}};
    end else begin
      rd2_scalar = scalar_r[a2];
      rd2_vector = vector_r[a2];
    end
    if (is_zero_reg(a3)) begin
      rd3_scalar = {SW{1'b0}};
      rd3_vector = {VW{1'b0}};
    end else begin
      rd3_scalar = scalar_r[a3];
      rd3_vector = vector_r[a3];
    end
  end

endmodule

// File: tb/tb_simd_regfile_pair.sv
// Bench for simd_regfile_pair: directed steps then random traffic against array models,
// with one instance using an ordinary register 0 and one with register 0 hardwired to zero.
module tb_simd_regfile_pair;

  logic         clk;
  logic         reset;
  logic         wre;
  logic [4:0]   a1, a2, a3;
  logic [15:0]  wd3_scalar;
  logic [127:0] wd3_vector;
  logic [15:0]  rd1_s, rd2_s, rd3_s, zrd1_s, zrd2_s, zrd3_s;
  logic [127:0] rd1_v, rd2_v, rd3_v, zrd1_v, zrd2_v, zrd3_v;

  int errors = 0;
  int checks = 0;

  // Reference contents: m_* for the ordinary instance, z_* for the zero-register instance.
  logic [15:0]  m_s [32];
  logic [127:0] m_v [32];
  logic [15:0]  z_s [32];
  logic [127:0] z_v [32];

  simd_regfile_pair #(.ZERO_REG(0)) dut (
    .clk(clk), .reset(reset), .wre(wre), .a1(a1), .a2(a2), .a3(a3),
    .wd3_scalar(wd3_scalar), .wd3_vector(wd3_vector),
    .rd1_scalar(rd1_s), .rd2_scalar(rd2_s), .rd3_scalar(rd3_s),
    .rd1_vector(rd1_v), .rd2_vector(rd2_v), .rd3_vector(rd3_v)
  );

  simd_regfile_pair #(.ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset), .wre(wre), .a1(a1), .a2(a2), .a3(a3),
    .wd3_scalar(wd3_scalar), .wd3_vector(wd3_vector),
    .rd1_scalar(zrd1_s), .rd2_scalar(zrd2_s), .rd3_scalar(zrd3_s),
    .rd1_vector(zrd1_v), .rd2_vector(zrd2_v), .rd3_vector(zrd3_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] zs(input logic [4:0] a);
    return (a == 5'd0) ? 16'h0000 : z_s[a];
  endfunction

  function automatic logic [127:0] zv(input logic [4:0] a);
    return (a == 5'd0) ? 128'h0 : z_v[a];
  endfunction

  task automatic check_all(input string ph);
    chk({ph, " rd1_s"}, {112'h0, rd1_s}, {112'h0, m_s[a1]});
    chk({ph, " rd2_s"}, {112'h0, rd2_s}, {112'h0, m_s[a2]});
    chk({ph, " rd3_s"}, {112'h0, rd3_s}, {112'h0, m_s[a3]});
    chk({ph, " rd1_v"}, rd1_v, m_v[a1]);
    chk({ph, " rd2_v"}, rd2_v, m_v[a2]);
    chk({ph, " rd3_v"}, rd3_v, m_v[a3]);
    chk({ph, " z rd1_s"}, {112'h0, zrd1_s}, {112'h0, zs(a1)});
    chk({ph, " z rd2_s"}, {112'h0, zrd2_s}, {112'h0, zs(a2)});
    chk({ph, " z rd3_s"}, {112'h0, zrd3_s}, {112'h0, zs(a3)});
    chk({ph, " z rd1_v"}, zrd1_v, zv(a1));
    chk({ph, " z rd2_v"}, zrd2_v, zv(a2));
    chk({ph, " z rd3_v"}, zrd3_v, zv(a3));
  endtask

  // One clock: reads must show old contents before the edge, new contents after it.
  task automatic step(input string ph, input bit pre_check);
    #1;
    if (pre_check) check_all({ph, " pre"});
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_s[i] = 16'h0; m_v[i] = 128'h0; z_s[i] = 16'h0; z_v[i] = 128'h0;
      end
    end else if (wre) begin
      m_s[a3] = wd3_scalar;
      m_v[a3] = wd3_vector;
      if (a3 != 5'd0) begin
        z_s[a3] = wd3_scalar;
        z_v[a3] = wd3_vector;
      end
    end
    #1 check_all({ph, " post"});
  endtask

  initial begin
    reset = 1'b1; wre = 1'b0; a1 = 5'd0; a2 = 5'd0; a3 = 5'd0;
    wd3_scalar = 16'h0; wd3_vector = 128'h0;
    @(posedge clk);
    step("init_reset", 1'b0);
    a1 = 5'd13; a2 = 5'd31; a3 = 5'd22;
    #1 check_all("reset_any_addr");

    // Reset clears a previously written register
    reset = 1'b0; wre = 1'b1; a3 = 5'd5; a1 = 5'd5;
    wd3_scalar = 16'hBEEF; wd3_vector = 128'h1234;
    step("wr5", 1'b1);
    chk("wr5 rd1_s const", {112'h0, rd1_s}, 128'hBEEF);
    reset = 1'b1; wre = 1'b0;
    step("rst_clear", 1'b1);
    chk("rst_clear rd1_s const", {112'h0, rd1_s}, 128'h0);
    chk("rst_clear rd1_v const", rd1_v, 128'h0);

    // Basic write/read on all three ports, no bypass before the edge
    reset = 1'b0; wre = 1'b1; a1 = 5'd1; a2 = 5'd1; a3 = 5'd1;
    wd3_scalar = 16'h0001; wd3_vector = 128'h1;
    #1 chk("basic pre rd3_s const", {112'h0, rd3_s}, 128'h0);
    chk("basic pre rd1_v const", rd1_v, 128'h0);
    step("basic", 1'b1);
    chk("basic rd2_s const", {112'h0, rd2_s}, 128'h1);
    chk("basic rd3_v const", rd3_v, 128'h1);

    // Write disabled for three edges
    wre = 1'b0; a3 = 5'd2; wd3_scalar = 16'hFFFF; wd3_vector = {128{1'b1}};
    for (int i = 0; i < 3; i++) step("wre0", 1'b1);
    chk("wre0 rd3_s const", {112'h0, rd3_s}, 128'h0);
    chk("wre0 rd3_v const", rd3_v, 128'h0);

    // Independent ports and lane placement
    wre = 1'b1; a3 = 5'd3; wd3_scalar = 16'h0033; wd3_vector = {8{16'h0303}};
    step("wr3", 1'b1);
    a3 = 5'd4; wd3_scalar = 16'h0044; wd3_vector = {8{16'h0404}};
    step("wr4", 1'b1);
    wre = 1'b0; a1 = 5'd3; a2 = 5'd4; a3 = 5'd0;
    #1 chk("indep rd1_s", {112'h0, rd1_s}, 128'h0033);
    chk("indep rd2_s", {112'h0, rd2_s}, 128'h0044);
    chk("indep rd1_v lane7", {112'h0, rd1_v[127:112]}, 128'h0303);
    chk("indep rd2_v lane0", {112'h0, rd2_v[15:0]}, 128'h0404);

    // Reset has priority over a simultaneous write
    reset = 1'b1; wre = 1'b1; a3 = 5'd7; a1 = 5'd7; wd3_scalar = 16'hAAAA; wd3_vector = {8{16'hAAAA}};
    step("rst_vs_wr", 1'b1);
    reset = 1'b0; wre = 1'b0;
    #1 chk("rst_vs_wr rd1_s const", {112'h0, rd1_s}, 128'h0);
    chk("rst_vs_wr rd1_v const", rd1_v, 128'h0);

    // Boundary address 31
    wre = 1'b1; a3 = 5'd31; wd3_scalar = 16'h7FFF; wd3_vector = {128{1'b1}};
    step("wr31", 1'b1);
    wre = 1'b0; a1 = 5'd0; a2 = 5'd30;
    #1 chk("b31 rd3_s", {112'h0, rd3_s}, 128'h7FFF);
    chk("b31 rd3_v", rd3_v, {128{1'b1}});
    chk("b31 rd1_s reg0", {112'h0, rd1_s}, 128'h0);
    chk("b31 rd2_v reg30", rd2_v, 128'h0);

    // Register 0 write: ordinary in one instance, discarded in the other
    wre = 1'b1; a3 = 5'd0; wd3_scalar = 16'h5A5A; wd3_vector = {8{16'hC3C3}};
    step("wr0", 1'b1);
    wre = 1'b0;
    #1 chk("wr0 rd3_s", {112'h0, rd3_s}, 128'h5A5A);
    chk("wr0 z rd3_s", {112'h0, zrd3_s}, 128'h0);
    chk("wr0 z rd3_v", zrd3_v, 128'h0);

    // Random traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 31) == 0);
      wre = 1'($urandom_range(0, 1));
      a1 = 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      a3 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      wd3_scalar = 16'($urandom);
      wd3_vector = {$urandom, $urandom, $urandom, $urandom};
      step("rand", 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simd_regfile_pair.md
Name: simd_regfile_pair

Overview:
- Combined architectural register storage for the CPU: one scalar register file (32 x 16-bit) and one vector register file (32 x 128-bit, eight 16-bit lanes).
- Sits between decode (read addresses) and writeback (write data).
- Provides three combinational read ports per file and one synchronous write port per file, sharing a common address set.

Parameters:
- NREGS, 32, registers per file; address width is clog2(NREGS) = 5.
- SW, 16, scalar register width in bits.
- VW, 128, vector register width in bits; must be a multiple of SW.
- ZERO_REG, 0, when 1, register 0 of both files reads as zero and ignores writes; when 0, register 0 is ordinary.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high; clears every register in both files.
- wre, input, 1, write enable, shared by both files.
- a1, input, 5, read address for port 1.
- a2, input, 5, read address for port 2.
- a3, input, 5, write address and read address for port 3.
- wd3_scalar, input, 16, scalar write data.
- wd3_vector, input, 128, vector write data.
- rd1_scalar, output, 16, scalar register[a1].
- rd2_scalar, output, 16, scalar register[a2].
- rd3_scalar, output, 16, scalar register[a3].
- rd1_vector, output, 128, vector register[a1].
- rd2_vector, output, 128, vector register[a2].
- rd3_vector, output, 128, vector register[a3].

Behaviour:
- Storage: scalar array of NREGS x SW flops; vector array of NREGS x VW flops. No memory macros.
- Reset: on a rising edge of clk with reset=1, all scalar and vector registers become 0. Reset has priority over a simultaneous write.
- Reset value of outputs: once reset has been applied, every rd* output reads 0, whatever the addresses.
- Before the first reset, contents are unspecified (X in simulation).
- Write: on a rising edge with reset=0 and wre=1:
  - scalar[a3] <= wd3_scalar and vector[a3] <= wd3_vector, both in the same cycle.
  - wre=0 leaves both files unchanged.
  - X or Z on wre is treated as no write.
- Read: purely combinational (zero latency); rdN_* follow aN and the current register contents within the same cycle.
- Read-during-write:
  - No internal bypass. In the cycle a write is presented, rd ports addressing a3 show the old value.
  - The new value appears immediately after the rising edge.
  - Writeback forwarding is the pipeline's responsibility.
- rd3 ports always reflect register[a3], used e.g. as store-data source; a3 is simultaneously the write target.
- Identical addresses on several ports return identical data; there is no port conflict.
- ZERO_REG=1: rd* with address 0 return 0, and writes to address 0 are discarded in both files.
- Vector lanes: lane i occupies bits [16*i+15 : 16*i], lane 0 in the LSBs. A write always updates the full 128 bits; there are no lane enables.
- Reset asserted mid-stream: takes effect on the next edge, overriding any pending write; operation resumes on the first edge after reset deasserts.

Test Plan:
- Reset clears: write scalar[5]=16'hBEEF and vector[5]=128'h1234 while reset=0, then hold reset=1 for one edge and set a1=5 -> rd1_scalar=0, rd1_vector=0.
- Basic write/read:
  - Stimulus: after reset, wre=1, a1=a2=a3=1, wd3_scalar=16'h0001, wd3_vector=128'h1.
  - Before the edge: rd1/2/3 read 0.
  - After the edge: rd1_scalar=rd2_scalar=rd3_scalar=16'h0001 and all rd*_vector=128'h1.
- Write disable: wre=0, a3=2, wd3_scalar=16'hFFFF, wd3_vector all ones, clock 3 edges -> rd3_scalar=0, rd3_vector=0.
- Independent ports:
  - Stimulus: write reg 3=16'h0033 / vector {8{16'h0303}}, and reg 4=16'h0044 / vector {8{16'h0404}}; then set a1=3, a2=4, a3=0.
  - Required: rd1_scalar=16'h0033, rd2_scalar=16'h0044, rd1_vector lane 7=16'h0303, rd2_vector lane 0=16'h0404.
- Reset vs write in the same cycle: reset=1, wre=1, a3=7, wd3_scalar=16'hAAAA -> after the edge, register 7 reads 0 in both files.
- Boundary address: write a3=31 with 16'h7FFF and 128 bits of all ones -> register 31 reads those values; registers 0 and 30 remain 0.
